// File: rtl/sift_ori_pkg.sv
// Shared defaults and FSM encoding for the orientation-histogram accumulator.
package sift_ori_pkg;

   localparam int unsigned BINS_DEF  = 32;
   localparam int unsigned DIR_W_DEF = 5;
   localparam int unsigned MAG_W_DEF = 12;
   localparam int unsigned ACC_W_DEF = 20;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACCUM = 3'd2,
      ST_SCAN  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/ori_peak_cmp.sv
// Running-max step: candidate replaces current only if strictly greater,
// so the lowest index wins among equal maxima.
module ori_peak_cmp #(
   parameter int unsigned DIR_W = 5,
   parameter int unsigned ACC_W = 20
) (
   input  logic [ACC_W-1:0] cur_max,
   input  logic [DIR_W-1:0] cur_idx,
   input  logic [ACC_W-1:0] cand_val,
   input  logic [DIR_W-1:0] cand_idx,
   output logic [ACC_W-1:0] nxt_max_c,
   output logic [DIR_W-1:0] nxt_idx_c
);

   always_comb begin
      nxt_max_c = cur_max;
      nxt_idx_c = cur_idx;
      if (cand_val > cur_max) begin
         nxt_max_c = cand_val;
         nxt_idx_c = cand_idx;
      end
   end

endmodule

// File: rtl/ori_hist_acc.sv
// Orientation histogram: accumulates weighted magnitudes per direction bin,
// then scans all bins once to report the peak bin and its value.
module ori_hist_acc
   import sift_ori_pkg::*;
#(
   parameter int unsigned BINS  = BINS_DEF,
   parameter int unsigned DIR_W = DIR_W_DEF,
   parameter int unsigned MAG_W = MAG_W_DEF,
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIR_W-1:0] in_dir,
   input  logic [MAG_W-1:0] in_mag,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIR_W-1:0] out_bin,
   output logic [ACC_W-1:0] out_peak,
   output logic             busy
);

   state_t state_q, state_d;

   logic [ACC_W-1:0] bins_q [BINS];
   logic [DIR_W-1:0] scan_idx_q;
   logic [ACC_W-1:0] max_q;
   logic [DIR_W-1:0] idx_q;

   logic             acc_c;
   logic             scan_last_c;
   logic [ACC_W:0]   sum_c;
   logic [ACC_W-1:0] sat_c;
   logic [ACC_W-1:0] nxt_max_c;
   logic [DIR_W-1:0] nxt_idx_c;

   assign acc_c       = (state_q == ST_ACCUM) && in_valid;
   assign scan_last_c = (scan_idx_q == DIR_W'(BINS - 1));

   // One spare carry bit detects overflow; clamp to all-ones instead of wrapping.
   assign sum_c = (ACC_W + 1)'(bins_q[in_dir]) + (ACC_W + 1)'(in_mag);
   assign sat_c = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];

   ori_peak_cmp #(
      .DIR_W (DIR_W),
      .ACC_W (ACC_W)
   ) u_peak_cmp (
      .cur_max   (max_q),
      .cur_idx   (idx_q),
      .cand_val  (bins_q[scan_idx_q]),
      .cand_idx  (scan_idx_q),
      .nxt_max_c (nxt_max_c),
      .nxt_idx_c (nxt_idx_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_CLEAR;
         ST_CLEAR: state_d = ST_ACCUM;
         ST_ACCUM: if (in_valid && in_last) state_d = ST_SCAN;
         ST_SCAN:  if (scan_last_c) state_d = ST_DONE;
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Status outputs registered from the next state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_d == ST_ACCUM);
         busy      <= (state_d != ST_IDLE);
         out_valid <= (state_d == ST_DONE);
      end
   end

   // Histogram storage and accumulate path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(BINS); i++) bins_q[i] <= '0;
      end else if (state_q == ST_CLEAR) begin
         for (int i = 0; i < int'(BINS); i++) bins_q[i] <= '0;
      end else if (acc_c) begin
         bins_q[in_dir] <= sat_c;
      end
   end

   // Scan walker; the result is latched on the final bin and held through IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_idx_q <= '0;
         max_q      <= '0;
         idx_q      <= '0;
         out_bin    <= '0;
         out_peak   <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               scan_idx_q <= '0;
               max_q      <= '0;
               idx_q      <= '0;
            end
            ST_SCAN: begin
               scan_idx_q <= scan_last_c ? '0 : scan_idx_q + DIR_W'(1);
               max_q      <= nxt_max_c;
               idx_q      <= nxt_idx_c;
               if (scan_last_c) begin
                  out_bin  <= nxt_idx_c;
                  out_peak <= nxt_max_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ori_hist_acc.sv
// Directed scoreboard bench for ori_hist_acc with default parameters.
module tb_ori_hist_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_dir;
   logic [11:0] in_mag;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_bin;
   logic [19:0] out_peak;
   logic        busy;

   typedef struct packed {
      logic [4:0]  bin;
      logic [19:0] peak;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   ori_hist_acc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dir    (in_dir),
      .in_mag    (in_mag),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_peak  (out_peak),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_win();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive one sample at a negedge where in_ready is high; returns just after the accept edge
   task automatic send(input logic [4:0] d, input logic [11:0] m, input logic l);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         in_valid = 1'b0;
         n++;
         @(negedge clk);
      end
      check("in_ready_seen", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_dir   = d;
      in_mag   = m;
      in_last  = l;
      @(posedge clk);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait for a result, optionally check latency, hold it for 'hold' cycles, then handshake
   task automatic wait_result(input int exp_lat, input int hold);
      int   cnt = 0;
      exp_t e;
      logic [4:0]  b;
      logic [19:0] p;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
         cnt++;
      end while (!out_valid && cnt < 400);
      check("out_valid_seen", 32'(out_valid), 32'd1);
      if (exp_lat > 0) check("latency", 32'(cnt), 32'(exp_lat));
      e = sb.pop_front();
      check("out_bin", 32'(out_bin), 32'(e.bin));
      check("out_peak", 32'(out_peak), 32'(e.peak));
      b = out_bin;
      p = out_peak;
      for (int k = 0; k < hold; k++) begin
         start = (k % 3 == 0);
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_bin", 32'(out_bin), 32'(b));
         check("hold_peak", 32'(out_peak), 32'(p));
      end
      out_ready = 1'b1;
      start     = (hold > 0);
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      check("post_busy", 32'(busy), 32'd0);
      check("post_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_bin_kept", 32'(out_bin), 32'(e.bin));
      check("idle_peak_kept", 32'(out_peak), 32'(e.peak));
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_dir    = '0;
      in_mag    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bin", 32'(out_bin), 32'd0);
      check("rst_peak", 32'(out_peak), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Uniform histogram: all bins 8, lowest index wins
      start_win();
      sb.push_back('{bin: 5'd0, peak: 20'd8});
      for (int i = 0; i < 256; i++) begin
         send(5'(i % 32), 12'd1, i == 255);
         if (i == 0) check("busy_accum", 32'(busy), 32'd1);
      end
      wait_result(0, 0);

      // Bin 7 reaches 150, bin 20 only 149; latency from last accept
      start_win();
      sb.push_back('{bin: 5'd7, peak: 20'd150});
      send(5'd7, 12'd100, 1'b0);
      send(5'd7, 12'd50, 1'b0);
      send(5'd20, 12'd149, 1'b1);
      wait_result(33, 0);

      // Saturation
      start_win();
      sb.push_back('{bin: 5'd3, peak: 20'd1048575});
      for (int i = 0; i < 300; i++) send(5'd3, 12'd4095, i == 299);
      wait_result(0, 0);

      // Back-pressure in DONE with start pulses ignored
      start_win();
      sb.push_back('{bin: 5'd12, peak: 20'd10});
      send(5'd12, 12'd5, 1'b0);
      send(5'd12, 12'd5, 1'b1);
      wait_result(0, 10);

      // Reset mid-ACCUM discards the window
      start_win();
      for (int i = 0; i < 5; i++) send(5'd4, 12'd100, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_ready", 32'(in_ready), 32'd0);
      check("arst_bin", 32'(out_bin), 32'd0);
      check("arst_peak", 32'(out_peak), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      check("no_stale_activity", 32'(seen), 32'd0);
      start_win();
      sb.push_back('{bin: 5'd9, peak: 20'd10});
      send(5'd9, 12'd10, 1'b1);
      wait_result(0, 0);

      // Gapped input stream
      start_win();
      sb.push_back('{bin: 5'd31, peak: 20'd32});
      for (int i = 0; i < 16; i++) begin
         send(5'd31, 12'd2, i == 15);
         if (i != 15) idle_cycle();
      end
      wait_result(0, 0);

      // All-zero histogram
      start_win();
      sb.push_back('{bin: 5'd0, peak: 20'd0});
      send(5'd17, 12'd0, 1'b1);
      wait_result(0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
